// File: rtl/reg_scoreboard.sv
// reg_scoreboard: register file with per-register pending-write counters, issue stall and writeback release.
module reg_scoreboard #(
    parameter  int NUM_REGS  = 32,
    parameter  int DATA_W    = 64,
    parameter  int RD_PORTS  = 3,
    parameter  int DST_PORTS = 2,
    parameter  int WB_PORTS  = 2,
    parameter  int CNT_W     = 2,
    parameter  int BYPASS    = 1,
    localparam int IDX_W     = $clog2(NUM_REGS)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [RD_PORTS-1:0]          i_rd_valid,
    input  logic [RD_PORTS*IDX_W-1:0]    i_rd_idx,
    output logic [RD_PORTS*DATA_W-1:0]   o_rd_data,
    output logic [RD_PORTS-1:0]          o_rd_busy,
    input  logic                         i_issue_valid,
    output logic                         o_issue_ready,
    input  logic [DST_PORTS-1:0]         i_dst_valid,
    input  logic [DST_PORTS*IDX_W-1:0]   i_dst_idx,
    input  logic [WB_PORTS-1:0]          i_wb_valid,
    input  logic [WB_PORTS*IDX_W-1:0]    i_wb_idx,
    input  logic [WB_PORTS*DATA_W-1:0]   i_wb_data,
    input  logic                         i_flush,
    output logic                         o_busy_any,
    output logic                         o_err_underflow
);
    // Sums are widened so cnt + claims - wbcount never wraps before the checks.
    localparam int SW = CNT_W + $clog2(DST_PORTS + WB_PORTS + 1) + 1;
    localparam logic [SW-1:0] MAX = SW'((1 << CNT_W) - 1);

    logic [DATA_W-1:0]   r_regs [NUM_REGS];
    logic [CNT_W-1:0]    r_cnt [NUM_REGS];
    logic                r_busy;
    logic                r_err;
    logic [SW-1:0]       w_wb [NUM_REGS];
    logic [SW-1:0]       w_cl [NUM_REGS];
    logic [SW-1:0]       w_rel [NUM_REGS];
    logic [SW-1:0]       w_tot [NUM_REGS];
    logic [CNT_W-1:0]    w_cnt_nx [NUM_REGS];
    logic [NUM_REGS-1:0] w_fit;
    logic [NUM_REGS-1:0] w_under;
    logic                w_busy_nx;
    logic                w_fire;
    logic [IDX_W-1:0]    w_ri;

    always_comb begin
        w_busy_nx = 1'b0;
        for (int r = 0; r < NUM_REGS; r++) begin
            w_wb[r] = '0;
            w_cl[r] = '0;
            for (int j = 0; j < WB_PORTS; j++)
                w_wb[r] = w_wb[r] + SW'(i_wb_valid[j] && i_wb_idx[j*IDX_W +: IDX_W] == IDX_W'(r));
            for (int d = 0; d < DST_PORTS; d++)
                w_cl[r] = w_cl[r] + SW'(i_dst_valid[d] && i_dst_idx[d*IDX_W +: IDX_W] == IDX_W'(r));
            w_rel[r] = (BYPASS != 0) ? w_wb[r] : '0;
            w_fit[r] = SW'(r_cnt[r]) + w_cl[r] <= MAX + w_rel[r];
        end
        for (int r = 0; r < NUM_REGS; r++) begin
            w_tot[r] = SW'(r_cnt[r]) + (w_fire ? w_cl[r] : '0);
            w_under[r] = !i_flush && w_wb[r] > w_tot[r];
            w_cnt_nx[r] = (i_flush || w_under[r]) ? '0 : CNT_W'(w_tot[r] - w_wb[r]);
            w_busy_nx = w_busy_nx | (|w_cnt_nx[r]);
        end
    end

    always_comb begin
        o_rd_data = '0;
        o_rd_busy = '0;
        w_ri = '0;
        for (int i = 0; i < RD_PORTS; i++) begin
            w_ri = i_rd_idx[i*IDX_W +: IDX_W];
            o_rd_data[i*DATA_W +: DATA_W] = r_regs[w_ri];
            for (int j = 0; j < WB_PORTS; j++)
                if (BYPASS != 0 && i_wb_valid[j] && i_wb_idx[j*IDX_W +: IDX_W] == w_ri)
                    o_rd_data[i*DATA_W +: DATA_W] = i_wb_data[j*DATA_W +: DATA_W];
            o_rd_busy[i] = i_rd_valid[i] && SW'(r_cnt[w_ri]) > w_rel[w_ri];
        end
    end

    assign o_issue_ready   = i_issue_valid && !i_flush && !(|o_rd_busy) && (&w_fit);
    assign w_fire          = i_issue_valid && o_issue_ready;
    assign o_busy_any      = r_busy;
    assign o_err_underflow = r_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_regs[r] <= '0;
                r_cnt[r]  <= '0;
            end
            r_busy <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++)
                r_cnt[r] <= w_cnt_nx[r];
            // Ascending port order so the highest writeback port wins on a collision.
            for (int j = 0; j < WB_PORTS; j++)
                if (i_wb_valid[j])
                    r_regs[i_wb_idx[j*IDX_W +: IDX_W]] <= i_wb_data[j*DATA_W +: DATA_W];
            r_busy <= w_busy_nx;
            r_err  <= r_err | (|w_under);
        end
    end
endmodule

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard: table-driven checks of the bypassing scoreboard plus a short sequence on a non-bypassing build.
module tb_reg_scoreboard;
    logic         clk = 1'b0;
    logic         reset;
    logic [2:0]   rd_valid;
    logic [14:0]  rd_idx;
    logic [191:0] rd_data_a, rd_data_b;
    logic [2:0]   rd_busy_a, rd_busy_b;
    logic         issue_valid;
    logic         rdy_a, rdy_b;
    logic [1:0]   dst_valid;
    logic [9:0]   dst_idx;
    logic [1:0]   wb_valid;
    logic [9:0]   wb_idx;
    logic [127:0] wb_data;
    logic         flush;
    logic         bany_a, bany_b, err_a, err_b;
    int           total = 0;
    int           bad = 0;

    always #5 clk = ~clk;

    reg_scoreboard #(.BYPASS(1)) dut_a (
        .clk(clk), .reset(reset), .i_rd_valid(rd_valid), .i_rd_idx(rd_idx), .o_rd_data(rd_data_a),
        .o_rd_busy(rd_busy_a), .i_issue_valid(issue_valid), .o_issue_ready(rdy_a), .i_dst_valid(dst_valid),
        .i_dst_idx(dst_idx), .i_wb_valid(wb_valid), .i_wb_idx(wb_idx), .i_wb_data(wb_data), .i_flush(flush),
        .o_busy_any(bany_a), .o_err_underflow(err_a)
    );

    reg_scoreboard #(.BYPASS(0)) dut_b (
        .clk(clk), .reset(reset), .i_rd_valid(rd_valid), .i_rd_idx(rd_idx), .o_rd_data(rd_data_b),
        .o_rd_busy(rd_busy_b), .i_issue_valid(issue_valid), .o_issue_ready(rdy_b), .i_dst_valid(dst_valid),
        .i_dst_idx(dst_idx), .i_wb_valid(wb_valid), .i_wb_idx(wb_idx), .i_wb_data(wb_data), .i_flush(flush),
        .o_busy_any(bany_b), .o_err_underflow(err_b)
    );

    typedef struct {
        logic         rst;
        logic [2:0]   rv;
        logic [14:0]  ri;
        logic         iv;
        logic [1:0]   dv;
        logic [9:0]   di;
        logic [1:0]   wv;
        logic [9:0]   wi;
        logic [127:0] wd;
        logic         fl;
        logic [2:0]   e_busy;
        logic         e_rdy;
        logic         ck_d;
        logic [63:0]  e_d;
        logic         e_bany;
        logic         e_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst, logic [2:0] rv, logic [4:0] r0, logic [4:0] r1, logic [4:0] r2,
                                logic iv, logic [1:0] dv, logic [4:0] d0, logic [4:0] d1,
                                logic [1:0] wv, logic [4:0] w0, logic [4:0] w1, logic [63:0] wd0, logic [63:0] wd1,
                                logic fl, logic [2:0] eb, logic er, logic ck, logic [63:0] ed, logic ea, logic ee);
        vec_t v;
        v.rst = rst; v.rv = rv; v.ri = {r2, r1, r0}; v.iv = iv; v.dv = dv; v.di = {d1, d0};
        v.wv = wv; v.wi = {w1, w0}; v.wd = {wd1, wd0}; v.fl = fl;
        v.e_busy = eb; v.e_rdy = er; v.ck_d = ck; v.e_d = ed; v.e_bany = ea; v.e_err = ee;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        reset = v.rst; rd_valid = v.rv; rd_idx = v.ri; issue_valid = v.iv; dst_valid = v.dv;
        dst_idx = v.di; wb_valid = v.wv; wb_idx = v.wi; wb_data = v.wd; flush = v.fl;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    initial begin
        // rst rv  r0 r1 r2 iv dv d0 d1 wv w0 w1 wd0 wd1 fl | busy rdy ckd data bany err
        vecs.push_back(mk(0, 3'b000, 0, 0, 0, 1, 2'b01, 3, 0, 2'b00, 0, 0, 0, 0, 0, 3'b000, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 3'b001, 3, 0, 0, 1, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0, 3'b001, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 3'b001, 3, 0, 0, 1, 2'b00, 0, 0, 2'b01, 3, 0, 64'hDEADBEEF, 0, 0, 3'b000, 1, 1, 64'hDEADBEEF, 1, 0));
        vecs.push_back(mk(0, 3'b001, 3, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0, 3'b000, 0, 1, 64'hDEADBEEF, 0, 0));
        vecs.push_back(mk(0, 3'b000, 0, 0, 0, 1, 2'b01, 5, 0, 2'b00, 0, 0, 0, 0, 0, 3'b000, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 3'b000, 0, 0, 0, 1, 2'b01, 5, 0, 2'b00, 0, 0, 0, 0, 0, 3'b000, 1, 0, 0, 1, 0));
        vecs.push_back(mk(0, 3'b000, 0, 0, 0, 1, 2'b01, 5, 0, 2'b00, 0, 0, 0, 0, 0, 3'b000, 1, 0, 0, 1, 0));
        vecs.push_back(mk(0, 3'b000, 0, 0, 0, 1, 2'b01, 5, 0, 2'b00, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 3'b000, 0, 0, 0, 1, 2'b01, 5, 0, 2'b01, 5, 0, 64'h11, 0, 0, 3'b000, 1, 0, 0, 1, 0));
        vecs.push_back(mk(0, 3'b001, 5, 0, 0, 1, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0, 3'b001, 0, 1, 64'h11, 1, 0));
        vecs.push_back(mk(0, 3'b000, 0, 0, 0, 0, 2'b00, 0, 0, 2'b11, 5, 5, 64'h21, 64'h22, 0, 3'b000, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 3'b000, 0, 0, 0, 0, 2'b00, 0, 0, 2'b01, 5, 0, 64'h33, 0, 0, 3'b000, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 3'b001, 5, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0, 3'b000, 0, 1, 64'h33, 0, 0));
        vecs.push_back(mk(0, 3'b000, 0, 0, 0, 1, 2'b11, 7, 7, 2'b00, 0, 0, 0, 0, 0, 3'b000, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 3'b001, 7, 0, 0, 1, 2'b00, 0, 0, 2'b11, 7, 7, 64'h1, 64'h2, 0, 3'b000, 1, 1, 64'h2, 1, 0));
        vecs.push_back(mk(0, 3'b001, 7, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0, 3'b000, 0, 1, 64'h2, 0, 0));
        vecs.push_back(mk(0, 3'b000, 0, 0, 0, 1, 2'b11, 1, 2, 2'b00, 0, 0, 0, 0, 0, 3'b000, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 3'b000, 0, 0, 0, 1, 2'b01, 1, 0, 2'b00, 0, 0, 0, 0, 1, 3'b000, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 3'b111, 3, 1, 2, 1, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0, 3'b000, 1, 1, 64'hDEADBEEF, 0, 0));
        vecs.push_back(mk(0, 3'b000, 0, 0, 0, 1, 2'b01, 10, 0, 2'b00, 0, 0, 0, 0, 0, 3'b000, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 3'b000, 0, 0, 0, 0, 2'b00, 0, 0, 2'b01, 10, 0, 64'hAB, 0, 1, 3'b000, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 3'b001, 10, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0, 3'b000, 0, 1, 64'hAB, 0, 0));
        vecs.push_back(mk(0, 3'b000, 0, 0, 0, 0, 2'b00, 0, 0, 2'b01, 9, 0, 64'h55, 0, 0, 3'b000, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 3'b001, 9, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0, 3'b000, 0, 1, 64'h55, 0, 1));
        vecs.push_back(mk(0, 3'b000, 0, 0, 0, 1, 2'b01, 11, 0, 2'b00, 0, 0, 0, 0, 0, 3'b000, 1, 0, 0, 0, 1));
        vecs.push_back(mk(1, 3'b000, 0, 0, 0, 1, 2'b01, 12, 0, 2'b01, 3, 0, 64'h99, 0, 0, 3'b000, 1, 0, 0, 1, 1));
        vecs.push_back(mk(0, 3'b111, 3, 11, 12, 1, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0, 3'b000, 1, 1, 64'h0, 0, 0));
        vecs.push_back(mk(0, 3'b001, 9, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0, 3'b000, 0, 1, 64'h0, 0, 0));

        drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge clk);

        for (int k = 0; k < vecs.size(); k++) begin
            @(negedge clk);
            drive(vecs[k]);
            #1;
            check($sformatf("v%0d rd_busy", k), 64'(rd_busy_a), 64'(vecs[k].e_busy));
            check($sformatf("v%0d issue_ready", k), 64'(rdy_a), 64'(vecs[k].e_rdy));
            check($sformatf("v%0d busy_any", k), 64'(bany_a), 64'(vecs[k].e_bany));
            check($sformatf("v%0d err_underflow", k), 64'(err_a), 64'(vecs[k].e_err));
            if (vecs[k].ck_d)
                check($sformatf("v%0d rd_data0", k), rd_data_a[63:0], vecs[k].e_d);
        end

        // Non-bypassing build: a writeback does not release the reader in its own cycle.
        @(negedge clk);
        drive(mk(0, 3'b000, 0, 0, 0, 1, 2'b01, 4, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        check("nb claim ready", 64'(rdy_b), 64'(1));
        @(negedge clk);
        drive(mk(0, 3'b001, 4, 0, 0, 1, 2'b00, 0, 0, 2'b01, 4, 0, 64'h44, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        check("nb wb-cycle busy", 64'(rd_busy_b), 64'(3'b001));
        check("nb wb-cycle ready", 64'(rdy_b), 64'(0));
        check("nb wb-cycle data", rd_data_b[63:0], 64'h0);
        check("nb wb-cycle busy_any", 64'(bany_b), 64'(1));
        @(negedge clk);
        drive(mk(0, 3'b001, 4, 0, 0, 1, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        check("nb after busy", 64'(rd_busy_b), 64'(0));
        check("nb after ready", 64'(rdy_b), 64'(1));
        check("nb after data", rd_data_b[63:0], 64'h44);
        check("nb after busy_any", 64'(bany_b), 64'(0));
        check("nb err", 64'(err_b), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Parametrised register file with a write-tracking scoreboard for the in-order x86 pipeline.
- Sits between decode and execute. Supplies operand values, raises a stall when a source operand is still pending, and claims destinations at issue.
- Releases destinations at writeback, with optional same-cycle bypass.
- Extends the single-target, single-writeback occupancy bit to per-register pending-write counters, multiple destinations per uop, multiple writeback ports, and pipeline flush.

Parameters:
- NUM_REGS, 32, number of architectural registers; IDX_W = $clog2(NUM_REGS).
- DATA_W, 64, register width.
- RD_PORTS, 3, source operand ports.
- DST_PORTS, 2, destinations claimable per issue.
- WB_PORTS, 2, writeback ports.
- CNT_W, 2, pending-write counter width; max outstanding writes per register = 2^CNT_W-1.
- BYPASS, 1, 1 enables writeback-to-read forwarding and same-cycle release.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- rd_valid  in  RD_PORTS  source port in use.
- rd_idx  in  RD_PORTS*IDX_W  source register indices.
- rd_data  out  RD_PORTS*DATA_W  source values.
- rd_busy  out  RD_PORTS  source has an unresolved pending write.
- issue_valid  in  1  decode presents a uop.
- issue_ready  out  1  uop may issue this cycle.
- dst_valid  in  DST_PORTS  destination in use.
- dst_idx  in  DST_PORTS*IDX_W  destination indices.
- wb_valid  in  WB_PORTS  writeback strobe.
- wb_idx  in  WB_PORTS*IDX_W  writeback indices.
- wb_data  in  WB_PORTS*DATA_W  writeback values.
- flush  in  1  discard all pending claims.
- busy_any  out  1  some counter is nonzero.
- err_underflow  out  1  sticky: writeback to a register with counter 0.

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - All registers and counters go to 0; err_underflow goes to 0.
  - Reset dominates flush, issue and wb in the same cycle.
  - Reset mid-operation drops all pending claims.
  - After reset: busy_any=0, rd_busy=0, issue_ready=issue_valid&&!flush.
- rd_data (combinational):
  - Default is regs[rd_idx].
  - If BYPASS and some wb_valid[j] has wb_idx[j]==rd_idx, output wb_data from the highest such j.
  - Ports with rd_valid=0 output regs[rd_idx]; their value is don't-care for checking.
- rd_busy[i] (combinational):
  - rd_valid[i] && cnt[idx] > rel[idx].
  - rel[idx] = number of wb ports hitting idx this cycle if BYPASS, else 0.
- issue_ready (combinational):
  - issue_valid && !flush && no rd_busy.
  - For every register, cnt[idx] + claims[idx] - rel[idx] <= 2^CNT_W-1.
  - claims[idx] = number of dst ports with dst_valid whose dst_idx==idx; duplicate destinations count separately.
- Fire = issue_valid && issue_ready. There is no registered latency on the issue decision.
- Counter update at clk edge:
  - cnt_next = cnt + (fire ? claims : 0) - wbcount.
  - wbcount = number of wb ports hitting idx.
  - With BYPASS=0, issue still sees rel=0, but the counter update still subtracts wbcount.
- Register write at clk edge:
  - Every wb_valid writes regs[wb_idx] on the next edge.
  - Multiple wb ports to the same idx: the highest port index wins.
- Underflow:
  - If wbcount > cnt (+claims if fire) for a register, the counter saturates at 0 and err_underflow sets (sticky until reset).
  - Data is still written.
- Flush:
  - All counters go to 0 at the next edge. No issue fires in that cycle.
  - wb in the flush cycle still writes data, does not decrement, and does not flag underflow.
  - Register contents are retained.
- busy_any is registered: OR of all counters after the update.
- Writeback order per register is in-order. The block does not reorder writes to the same register.

Test Plan:
1. Reset, then issue dst r3 (RD none) → cnt[3]=1, busy_any=1. Next cycle, a read of r3 gives rd_busy=1, issue_ready=0. Then wb r3=0xDEAD_BEEF → with BYPASS, in the same cycle rd_busy=0, rd_data=0xDEADBEEF, issue_ready=1. The next cycle cnt[3]=0.
2. Issue dst r5 three times (CNT_W=2) → cnt=3. A fourth issue to r5 gives issue_ready=0. A simultaneous wb r5 in that cycle gives issue_ready=1 and cnt stays 3.
3. Two dst ports both to r7, then wb0 r7=1 and wb1 r7=2 in the same cycle → cnt[7] 2→0, regs[7]=2, and a read of r7 that cycle returns 2.
4. With r1 and r2 pending, assert flush with issue_valid=1 → issue_ready=0. Next cycle all counters are 0, busy_any=0, and regs are unchanged.
5. wb r9=0x55 with cnt[9]=0 → regs[9]=0x55 and err_underflow=1, which stays 1 until reset. Reset asserted alongside issue and wb → all state is 0 afterwards.
6. BYPASS=0 build, pending r4, wb r4 → rd_busy[r4]=1 in the wb cycle, 0 the next cycle, and rd_data is the new value.
